// File: rtl/mips_arb_pkg.sv
// Shared types for the IF/MEM unified memory-port arbiter: FSM states, owner
// encoding, default widths and the perf counter helper.
package mips_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DM_ACC = 2'd1,
    IF_ACC = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_own_t;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;
  localparam int PERF_W = 32;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + PERF_W'(1);
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Access watchdog: cleared on grant, counts stalled access cycles, flags the
// cycle that completes TIMEOUT waiting cycles. TIMEOUT=0 never flags.
module mem_arb_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 cnt <= '0;
    else if (clr)                            cnt <= '0;
    else if (en && (cnt != CW'(TIMEOUT)))    cnt <= cnt + CW'(1);
  end

  // Flag fires in the TIMEOUT-th waiting cycle so the request is held exactly TIMEOUT cycles.
  assign tc = (TIMEOUT != 0) && en && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Unified memory-port arbiter for the IF and MEM stages; data port has priority.
// Optional ARB_PERF_EN adds saturating stall-cycle counters perf_if_wait/perf_dm_wait.
module mem_arbiter
  import mips_arb_pkg::*;
#(
  parameter int          AW      = DEF_AW,
  parameter int          DW      = DEF_DW,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic          if_done,
  output logic [DW-1:0] if_rdata,
  output logic          if_stall,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_done,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_err,
  output logic          dm_stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
`ifdef ARB_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_if_wait,
  output logic [PERF_W-1:0] perf_dm_wait
`endif
);

  arb_state_t state, state_nx;
  arb_own_t   cur_own;
  logic       grant_dm, grant_if, grant;
  logic       in_acc, fin, tmo_tc;
  logic       kill, kill_nx;

  assign in_acc  = (state == DM_ACC) || (state == IF_ACC);
  assign cur_own = (state == DM_ACC) ? OWN_DM : OWN_IF;
  assign grant   = grant_dm | grant_if;
  // mem_ready wins over a coincident timeout
  assign fin     = in_acc && (mem_ready || tmo_tc);
  assign kill_nx = kill || ((state == IF_ACC) && if_flush);

  mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (grant),
    .en  (in_acc && !mem_ready),
    .tc  (tmo_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    grant_dm = 1'b0;
    grant_if = 1'b0;
    case (state)
      IDLE: begin
        if (dm_req) begin
          grant_dm = 1'b1;
          state_nx = DM_ACC;
        end else if (if_req && !if_flush) begin
          grant_if = 1'b1;
          state_nx = IF_ACC;
        end
      end
      DM_ACC, IF_ACC: if (mem_ready || tmo_tc) state_nx = RESP;
      RESP:           state_nx = IDLE;
      default:        state_nx = IDLE;
    endcase
  end

  // Done/err flops are set on the edge into RESP, so they are high exactly during RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_done   <= 1'b0;
      dm_done   <= 1'b0;
      dm_err    <= 1'b0;
      kill      <= 1'b0;
    end else begin
      if_done <= 1'b0;
      dm_done <= 1'b0;
      dm_err  <= 1'b0;

      if (grant) begin
        mem_req  <= 1'b1;
        mem_we   <= grant_dm & dm_we;
        mem_addr <= grant_dm ? dm_addr : if_addr;
        if (grant_dm) mem_wdata <= dm_wdata;
      end

      if (fin) begin
        mem_req <= 1'b0;
        if (cur_own == OWN_DM) begin
          dm_done <= 1'b1;
          dm_err  <= !mem_ready;
          if (mem_ready && !mem_we) dm_rdata <= mem_rdata;
        end else if (!kill_nx) begin
          if_done <= 1'b1;
          dm_err  <= !mem_ready;
          if (mem_ready) if_rdata <= mem_rdata;
        end
      end

      // A redirected fetch still finishes on memory but its response is dropped.
      if (state == RESP)                       kill <= 1'b0;
      else if ((state == IF_ACC) && if_flush)  kill <= 1'b1;
    end
  end

  assign if_stall = if_req & ~if_done;
  assign dm_stall = dm_req & ~dm_done;

`ifdef ARB_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_if_wait <= '0;
      perf_dm_wait <= '0;
    end else begin
      if (if_stall) perf_if_wait <= sat_inc(perf_if_wait);
      if (dm_stall) perf_dm_wait <= sat_inc(perf_dm_wait);
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, directed corner sequences
// and a randomized phase checked against a memory/scoreboard model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 0, if_flush = 0, dm_req = 0, dm_we = 0, mem_ready = 0;
  logic [31:0] if_addr = 0, dm_addr = 0, dm_wdata = 0, mem_rdata = 0;
  logic        if_done, if_stall, dm_done, dm_err, dm_stall, mem_req, mem_we;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
`ifdef ARB_PERF_EN
  logic [31:0] perf_if_wait, perf_dm_wait;
`endif

  mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_rdata(if_rdata), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_done(dm_done), .dm_rdata(dm_rdata), .dm_err(dm_err), .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
`ifdef ARB_PERF_EN
    .perf_if_wait(perf_if_wait), .perf_dm_wait(perf_dm_wait),
`endif
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Physical memory behind the port, and the bench's own view of it.
  logic [31:0] pmem [logic [31:0]];
  logic [31:0] mmem [logic [31:0]];
  int lat = 1;
  bit rand_lat = 0;
  int rcnt = 0;

  logic [31:0] exp_if = 0, exp_dm = 0;
  bit dm_busy = 0, if_busy = 0;
  logic p_dm_req = 0, p_dm_we = 0, pv_mem_req = 0;
  logic [31:0] p_dm_addr = 0, p_if_addr = 0, pv_mem_addr = 0;

  function automatic logic [31:0] prd(input logic [31:0] a);
    if (pmem.exists(a)) return pmem[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] mrd(input logic [31:0] a);
    if (mmem.exists(a)) return mmem[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // One cycle: step to the negedge and run the memory responder.
  task automatic tick();
    @(negedge clk);
    if (mem_req) begin
      rcnt++;
      if (rcnt == 1 && rand_lat) lat = $urandom_range(1, 4);
      if (lat != 0 && rcnt == lat) begin
        mem_ready = 1'b1;
        if (mem_we) pmem[mem_addr] = mem_wdata;
        else        mem_rdata = prd(mem_addr);
      end else begin
        mem_ready = 1'b0;
      end
    end else begin
      rcnt = 0;
      mem_ready = 1'b0;
    end
  endtask

  task automatic rnd_step(input bit allow_new);
    bit dd, id;
    tick();
    if (mem_req && !pv_mem_req) begin
      chk("rnd_grant_addr", mem_addr, p_dm_req ? p_dm_addr : p_if_addr);
      chk("rnd_grant_we", 32'(mem_we), 32'(p_dm_req & p_dm_we));
    end else if (mem_req) begin
      chk("rnd_hold_addr", mem_addr, pv_mem_addr);
    end
    chk("rnd_if_stall", 32'(if_stall), 32'(if_req & ~if_done));
    chk("rnd_dm_stall", 32'(dm_stall), 32'(dm_req & ~dm_done));
    chk("rnd_one_done", 32'(if_done & dm_done), 32'd0);
    dd = dm_done;
    id = if_done;
    if (dd) begin
      chk("rnd_dm_owner", 32'(dm_busy), 32'd1);
      if (dm_we) mmem[dm_addr] = dm_wdata;
      else       exp_dm = mrd(dm_addr);
      chk("rnd_dm_rdata", dm_rdata, exp_dm);
      dm_req = 0;
      dm_busy = 0;
    end
    if (id) begin
      chk("rnd_if_owner", 32'(if_busy), 32'd1);
      exp_if = mrd(if_addr);
      chk("rnd_if_rdata", if_rdata, exp_if);
      if_req = 0;
      if_busy = 0;
    end
    if (allow_new) begin
      if (!dm_busy && !dd && $urandom_range(0, 3) == 0) begin
        dm_busy = 1; dm_req = 1;
        dm_we = 1'($urandom_range(0, 1));
        dm_addr = 32'h1000 + ($urandom_range(0, 7) << 2);
        dm_wdata = $urandom;
      end
      if (!if_busy && !id && $urandom_range(0, 2) == 0) begin
        if_busy = 1; if_req = 1;
        if_addr = 32'h1000 + ($urandom_range(0, 7) << 2);
      end
    end
    p_dm_req = dm_req; p_dm_we = dm_we; p_dm_addr = dm_addr; p_if_addr = if_addr;
    pv_mem_req = mem_req; pv_mem_addr = mem_addr;
  endtask

  typedef struct {
    bit          dm, we, pre, keep, exp_err;
    logic [31:0] addr, wdata, memval, exp_rd;
    int          lat, exp_done, exp_req;
  } vec_t;

  localparam int NV = 7;
  vec_t tbl [NV];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int got, nreq, ifd;
    bit hold_ok, other, stall_ok, addr_ok;
    logic [31:0] act, exp;

    //         dm we pre keep err addr          wdata         memval        exp_rd        lat done req
    tbl[0] = '{0, 0, 1, 0, 0, 32'h0000_0040, 32'h0,        32'h2008_0005, 32'h2008_0005, 1, 2, 1};
    tbl[1] = '{1, 0, 1, 0, 0, 32'h0000_0100, 32'h0,        32'h1234_5678, 32'h1234_5678, 2, 3, 2};
    tbl[2] = '{1, 1, 0, 1, 0, 32'h0000_0200, 32'hDEAD_BEEF, 32'h0,        32'h0,        3, 4, 3};
    tbl[3] = '{0, 0, 1, 0, 0, 32'h0000_0044, 32'h0,        32'h8C09_0000, 32'h8C09_0000, 5, 6, 5};
    tbl[4] = '{1, 0, 1, 1, 1, 32'h0000_0300, 32'h0,        32'hCAFE_0001, 32'h0,        0, 9, 8};
    tbl[5] = '{0, 0, 1, 1, 1, 32'h0000_0048, 32'h0,        32'hCAFE_0002, 32'h0,        0, 9, 8};
    tbl[6] = '{1, 0, 0, 0, 0, 32'h0000_0200, 32'h0,        32'h0,        32'hDEAD_BEEF, 2, 3, 2};

    // Reset state
    @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_dones", 32'({if_done, dm_done, dm_err}), 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      got = 0; nreq = 0; hold_ok = 1; other = 0;
      if (tbl[i].pre) begin
        pmem[tbl[i].addr] = tbl[i].memval;
        mmem[tbl[i].addr] = tbl[i].memval;
      end
      lat = tbl[i].lat;
      if (tbl[i].dm) begin
        dm_req = 1; dm_we = tbl[i].we; dm_addr = tbl[i].addr; dm_wdata = tbl[i].wdata;
      end else begin
        if_req = 1; if_addr = tbl[i].addr;
      end
      for (int k = 1; k <= 20; k++) begin
        tick();
        if (mem_req) begin
          nreq++;
          if (mem_addr !== tbl[i].addr || mem_we !== tbl[i].we ||
              (tbl[i].we && mem_wdata !== tbl[i].wdata)) hold_ok = 0;
        end
        if (tbl[i].dm ? if_done : dm_done) other = 1;
        if (tbl[i].dm ? dm_done : if_done) begin got = k; break; end
      end
      chk($sformatf("vec%0d_done_cycle", i), got, tbl[i].exp_done);
      chk($sformatf("vec%0d_req_cycles", i), nreq, tbl[i].exp_req);
      chk($sformatf("vec%0d_hold", i), 32'(hold_ok), 1);
      chk($sformatf("vec%0d_other_done", i), 32'(other), 0);
      chk($sformatf("vec%0d_err", i), 32'(dm_err), 32'(tbl[i].exp_err));
      act = tbl[i].dm ? dm_rdata : if_rdata;
      exp = tbl[i].keep ? (tbl[i].dm ? exp_dm : exp_if) : tbl[i].exp_rd;
      chk($sformatf("vec%0d_rdata", i), act, exp);
      if (tbl[i].dm) exp_dm = exp; else exp_if = exp;
      if (tbl[i].dm && tbl[i].we) mmem[tbl[i].addr] = tbl[i].wdata;
      dm_req = 0; if_req = 0;
      tick();
      chk($sformatf("vec%0d_pulse_end", i), 32'(tbl[i].dm ? dm_done : if_done), 0);
    end

    // Simultaneous requests: data first, fetch follows, fetch stalled throughout
    lat = 1;
    if_req = 1; if_addr = 32'h60; dm_req = 1; dm_we = 0; dm_addr = 32'h100;
    got = 0; stall_ok = 1; ifd = 0; addr_ok = 1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k == 0) chk("sim_first_addr", mem_addr, 32'h100);
      if (!if_stall) stall_ok = 0;
      if (if_done) ifd = 1;
      if (dm_done) begin got = 1; break; end
    end
    chk("sim_dm_done", got, 1);
    exp_dm = mrd(32'h100);
    chk("sim_dm_rdata", dm_rdata, exp_dm);
    dm_req = 0;
    got = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (mem_req && mem_addr !== 32'h60) addr_ok = 0;
      if (if_done) begin got = 1; break; end
      if (!if_stall) stall_ok = 0;
    end
    chk("sim_if_done", got, 1);
    chk("sim_if_early", ifd, 0);
    chk("sim_if_addr", 32'(addr_ok), 1);
    chk("sim_if_stall", 32'(stall_ok), 1);
    exp_if = mrd(32'h60);
    chk("sim_if_rdata", if_rdata, exp_if);
    if_req = 0;
    tick();

    // Flush: blocks grant in IDLE, kills response mid-access
    lat = 4;
    if_req = 1; if_addr = 32'h80; if_flush = 1;
    tick();
    chk("flush_idle_block", 32'(mem_req), 0);
    if_flush = 0;
    ifd = 0;
    for (int k = 2; k <= 6; k++) begin
      tick();
      if (k == 2) chk("flush_grant_addr", mem_addr, 32'h80);
      if (k == 3) begin if_flush = 1; if_addr = 32'hC0; end
      if (k == 4) if_flush = 0;
      if (if_done) ifd++;
    end
    chk("flush_no_done", ifd, 0);
    chk("flush_rdata_hold", if_rdata, exp_if);
    chk("flush_req_dropped", 32'(mem_req), 0);
    got = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (if_done) begin got = 1; break; end
    end
    chk("flush_next_done", got, 1);
    chk("flush_next_addr", mem_addr, 32'hC0);
    exp_if = mrd(32'hC0);
    chk("flush_next_rdata", if_rdata, exp_if);
    if_req = 0;
    tick();

    // Randomized traffic against the memory model
    rand_lat = 1;
    p_dm_req = 0; p_dm_we = 0; p_dm_addr = dm_addr; p_if_addr = if_addr;
    pv_mem_req = mem_req; pv_mem_addr = mem_addr;
    for (int n = 0; n < 400; n++) rnd_step(1);
    for (int n = 0; n < 60 && (dm_busy || if_busy); n++) rnd_step(0);
    chk("rnd_drained", 32'(dm_busy | if_busy), 0);
    rand_lat = 0;
    tick();

    // Reset in the middle of a data access
    lat = 0;
    dm_req = 1; dm_we = 1; dm_addr = 32'h400; dm_wdata = 32'h1111_2222;
    tick();
    tick();
    chk("rst_pre_req", 32'(mem_req), 1);
`ifdef ARB_PERF_EN
    chk("perf_dm_nonzero", 32'(perf_dm_wait != 0), 1);
`endif
    #2 rst = 1'b1;
    dm_req = 0;
    #1;
    chk("rst_mid_mem_req", 32'(mem_req), 0);
    chk("rst_mid_mem_we", 32'(mem_we), 0);
    chk("rst_mid_mem_addr", mem_addr, 0);
    chk("rst_mid_mem_wdata", mem_wdata, 0);
    chk("rst_mid_dones", 32'({if_done, dm_done, dm_err}), 0);
    chk("rst_mid_if_rdata", if_rdata, 0);
    chk("rst_mid_dm_rdata", dm_rdata, 0);
`ifdef ARB_PERF_EN
    chk("rst_perf_if", perf_if_wait, 0);
    chk("rst_perf_dm", perf_dm_wait, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("post_rst_idle", 32'(mem_req), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Arbitrates a single unified memory port between the IF stage (instruction fetch, read-only) and the MEM stage (lw/sw data access) of the 5-stage MIPS pipeline.
Sequences each access as a variable-latency req/ready transaction and returns registered read data with a one-cycle done pulse. Produces per-port stall signals that the hazard/stall logic ORs into the pipeline freeze, alongside the existing lw-use stall.
Data port always wins: the MEM-stage instruction is older.

Parameters:
AW, 32, address width (byte address)
DW, 32, data width
TIMEOUT, 255, max cycles waiting for mem_ready before error completion; 0 disables timeout

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
if_req  in  1  fetch request, held until if_done
if_addr  in  AW  fetch address
if_flush  in  1  branch/jump redirect; kills pending fetch response
if_done  out  1  one-cycle completion pulse for fetch
if_rdata  out  DW  fetched instruction, valid from if_done until next if_done
if_stall  out  1  if_req & ~if_done
dm_req  in  1  data request, held until dm_done
dm_we  in  1  1 = store (sw), 0 = load (lw)
dm_addr  in  AW  data address
dm_wdata  in  DW  store data
dm_done  out  1  one-cycle completion pulse for data
dm_rdata  out  DW  load data, valid from dm_done until next dm_done
dm_err  out  1  accompanies dm_done/if_done when the access timed out
dm_stall  out  1  dm_req & ~dm_done
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  write enable to memory
mem_addr  out  AW  latched address
mem_wdata  out  DW  latched store data
mem_rdata  in  DW  memory read data, valid with mem_ready
mem_ready  in  1  one-cycle memory completion

Behaviour:
- Clock/reset: one clock, clk. Reset is asynchronous and active-high, on rst.
- Reset values: state=IDLE. mem_req, mem_we, if_done, dm_done and dm_err are 0. mem_addr, mem_wdata, if_rdata, dm_rdata and the timer are 0.
- States:
  - IDLE, DM_ACC, IF_ACC, RESP.
- IDLE:
  - dm_req=1 -> DM_ACC.
  - else if_req=1 & ~if_flush -> IF_ACC.
  - else stay.
  - On a grant, latch addr, we (0 for IF) and wdata at the same edge; mem_req=1 from the next cycle.
- DM_ACC / IF_ACC:
  - mem_req, mem_addr, mem_we and mem_wdata are held stable until mem_ready.
  - On mem_ready: capture mem_rdata into the owner's rdata register (loads/fetches only; a store leaves dm_rdata unchanged), drop mem_req, go to RESP.
- RESP:
  - Owner's done=1 for exactly this cycle, then IDLE.
  - Requests are not sampled in RESP, so a req still high on the done cycle is not re-granted.
- Latency: grant edge +1 = mem_req. With mem_ready in the first mem_req cycle, done is asserted 2 cycles after req is first seen in IDLE. Back-to-back accesses cost at least 3 cycles each.
- Simultaneous requests: DM always first. IF is served on the next IDLE.
  - Starvation is bounded: the pipeline issues at most one DM access per instruction.
- Flush:
  - if_flush in IDLE blocks the IF grant.
  - if_flush during IF_ACC or the same cycle as mem_ready: the access completes on memory, a sticky kill bit is set, if_rdata is not updated and if_done is suppressed in RESP.
  - Kill clears on entry to IDLE.
- Timeout (TIMEOUT>0):
  - The timer counts cycles in *_ACC without mem_ready.
  - At timer==TIMEOUT: drop mem_req, go to RESP, assert done together with dm_err=1. Read data is not updated.
  - The timer clears on every grant.
- Reset mid-access: mem_req drops asynchronously and the access is abandoned. Memory must tolerate this.
- mem_ready outside *_ACC is ignored.

Optional Feature:
ARB_PERF_EN:
- Defined: adds outputs perf_if_wait (32) and perf_dm_wait (32). These saturating counters increment each cycle that if_stall or dm_stall is 1, respectively, and reset to 0.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package mips_arb_pkg holds:
  - the state enum (IDLE, DM_ACC, IF_ACC, RESP);
  - owner encoding (OWN_IF=0, OWN_DM=1);
  - default AW/DW;
  - PERF_W=32.
- One sub-module, mem_arb_timer: load/clear, enable and terminal-count flag parameterised by TIMEOUT. It is instantiated once.

Test Plan:
- Fetch only: if_req, if_addr=0x0000_0040, memory answers in 1 cycle with 0x2008_0005 -> mem_addr=0x40, if_done 2 cycles after req, if_rdata=0x2008_0005.
- Simultaneous requests: if_req and dm_req (lw, 0x100) in the same cycle -> DM granted first, dm_done, then the IF access follows. if_stall stays high throughout.
- Store: dm_we=1, dm_addr=0x200, dm_wdata=0xDEAD_BEEF, memory latency 3 -> mem_we=1 with stable addr/data for 3 cycles, dm_done pulse, dm_rdata unchanged.
- Flush: if_flush pulses mid IF_ACC, latency 4 -> the access completes, no if_done, if_rdata holds its old value, and the next if_req is granted normally.
- Timeout: TIMEOUT=8, mem_ready never asserted -> mem_req high for 8 cycles, then drops, dm_done=1 with dm_err=1, return to IDLE.
- Reset: assert rst during DM_ACC -> mem_req=0 immediately and all outputs at reset values. With ARB_PERF_EN defined, perf counters read 0.
